// File: rtl/systolic_result_packer_pkg.sv
// Shared definitions for the systolic array result path: frame states,
// header constant, word geometry and small byte-level helpers.
package systolic_result_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } pkr_state_e;

  localparam logic [7:0]  FRAME_HDR      = 8'hA5;
  localparam int unsigned RESULT_DW      = 32'd32;
  localparam int unsigned BYTES_PER_WORD = RESULT_DW / 32'd8;

  // Counter width for a count of items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned count);
    int unsigned w;
    if (count > 32'd1) begin
      w = $clog2(count);
    end else begin
      w = 32'd1;
    end
    return w;
  endfunction

  function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] data_byte);
    return csum ^ data_byte;
  endfunction

endpackage

// File: rtl/systolic_result_packer_word_byte_mux.sv
// Combinational selector: byte byte_sel of word word_sel from the capture buffer.
module systolic_result_packer_word_byte_mux
  import systolic_result_packer_pkg::*;
#(
  parameter int N   = 2,
  parameter int DW  = RESULT_DW,
  parameter int WIW = 2,
  parameter int BIW = 2
) (
  input  logic [N*N*DW-1:0] capture_buf,
  input  logic [WIW-1:0]    word_sel,
  input  logic [BIW-1:0]    byte_sel,
  output logic [7:0]        byte_out
);

  localparam int BPW   = DW / 8;
  localparam int TOTAL = N * N * BPW;

  // Out-of-range selections resolve to zero rather than wrapping.
  always_comb begin
    byte_out = 8'h00;
    for (int i = 0; i < TOTAL; i++) begin
      byte_out = ((i / BPW == int'(word_sel)) && (i % BPW == int'(byte_sel)))
                 ? capture_buf[i*8 +: 8] : byte_out;
    end
  end

endmodule

// File: rtl/systolic_result_packer.sv
// Captures the N x N systolic results on start and streams them to the UART
// transmitter as a frame: header, little-endian result bytes, XOR checksum.
module systolic_result_packer
  import systolic_result_packer_pkg::*;
#(
  parameter int         N   = 2,
  parameter int         DW  = RESULT_DW,
  parameter logic [7:0] HDR = FRAME_HDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*N*DW-1:0] c_flat,
  input  logic              start,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              busy,
  output logic              done
);

  localparam int WORDS = N * N;
  localparam int BPW   = DW / 8;
  localparam int WIW   = int'(idx_width(WORDS));
  localparam int BIW   = int'(idx_width(BPW));

  localparam logic [WIW-1:0] LAST_WORD = WIW'(WORDS - 1);
  localparam logic [BIW-1:0] LAST_BYTE = BIW'(BPW - 1);

  pkr_state_e          state_r, state_nx_s;
  logic [N*N*DW-1:0]   capture_r, capture_nx_s;
  logic [WIW-1:0]      word_idx_r, word_idx_nx_s, sel_word_s;
  logic [BIW-1:0]      byte_idx_r, byte_idx_nx_s, sel_byte_s;
  logic [7:0]          csum_r, csum_nx_s;
  logic [7:0]          tx_data_r, tx_data_nx_s;
  logic                tx_valid_r, tx_valid_nx_s;
  logic                busy_r, busy_nx_s;
  logic                done_r, done_nx_s;
  logic [7:0]          mux_byte_s;
  logic                xfer_s;
  logic                last_byte_s;
  logic                last_word_s;

  assign xfer_s   = tx_valid_r & tx_ready;
  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;
  assign busy     = busy_r;
  assign done     = done_r;

  // Position of the byte that follows the one currently presented.
  always_comb begin
    last_byte_s = (byte_idx_r == LAST_BYTE);
    last_word_s = (word_idx_r == LAST_WORD);
    sel_word_s  = word_idx_r;
    sel_byte_s  = byte_idx_r;
    if (state_r == ST_DATA) begin
      if (last_byte_s) begin
        sel_byte_s = {BIW{1'b0}};
        sel_word_s = word_idx_r + WIW'(1);
      end else begin
        sel_byte_s = byte_idx_r + BIW'(1);
        sel_word_s = word_idx_r;
      end
    end else begin
      sel_word_s = word_idx_r;
      sel_byte_s = byte_idx_r;
    end
  end

  systolic_result_packer_word_byte_mux #(
    .N   (N),
    .DW  (DW),
    .WIW (WIW),
    .BIW (BIW)
  ) u_word_byte_mux (
    .capture_buf (capture_r),
    .word_sel    (sel_word_s),
    .byte_sel    (sel_byte_s),
    .byte_out    (mux_byte_s)
  );

  // Frame sequencing: next state and next values of every output register.
  always_comb begin
    state_nx_s    = state_r;
    capture_nx_s  = capture_r;
    word_idx_nx_s = word_idx_r;
    byte_idx_nx_s = byte_idx_r;
    csum_nx_s     = csum_r;
    tx_data_nx_s  = tx_data_r;
    tx_valid_nx_s = tx_valid_r;
    busy_nx_s     = busy_r;
    done_nx_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s    = ST_HDR;
          capture_nx_s  = c_flat;
          word_idx_nx_s = {WIW{1'b0}};
          byte_idx_nx_s = {BIW{1'b0}};
          csum_nx_s     = 8'h00;
          tx_data_nx_s  = HDR;
          tx_valid_nx_s = 1'b1;
          busy_nx_s     = 1'b1;
        end else begin
          tx_valid_nx_s = 1'b0;
          busy_nx_s     = 1'b0;
        end
      end
      ST_HDR: begin
        if (xfer_s) begin
          state_nx_s   = ST_DATA;
          tx_data_nx_s = mux_byte_s;
        end else begin
          state_nx_s = ST_HDR;
        end
      end
      ST_DATA: begin
        if (xfer_s) begin
          csum_nx_s = csum_update(csum_r, tx_data_r);
          if (last_word_s && last_byte_s) begin
            state_nx_s   = ST_CSUM;
            tx_data_nx_s = csum_update(csum_r, tx_data_r);
          end else begin
            word_idx_nx_s = sel_word_s;
            byte_idx_nx_s = sel_byte_s;
            tx_data_nx_s  = mux_byte_s;
          end
        end else begin
          state_nx_s = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (xfer_s) begin
          state_nx_s    = ST_IDLE;
          tx_data_nx_s  = 8'h00;
          tx_valid_nx_s = 1'b0;
          busy_nx_s     = 1'b0;
          done_nx_s     = 1'b1;
        end else begin
          state_nx_s = ST_CSUM;
        end
      end
      default: begin
        state_nx_s    = ST_IDLE;
        tx_data_nx_s  = 8'h00;
        tx_valid_nx_s = 1'b0;
        busy_nx_s     = 1'b0;
      end
    endcase
  end

  // State, buffer, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      capture_r  <= {(N*N*DW){1'b0}};
      word_idx_r <= {WIW{1'b0}};
      byte_idx_r <= {BIW{1'b0}};
      csum_r     <= 8'h00;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      capture_r  <= capture_nx_s;
      word_idx_r <= word_idx_nx_s;
      byte_idx_r <= byte_idx_nx_s;
      csum_r     <= csum_nx_s;
      tx_data_r  <= tx_data_nx_s;
      tx_valid_r <= tx_valid_nx_s;
      busy_r     <= busy_nx_s;
      done_r     <= done_nx_s;
    end
  end

endmodule

// File: tb/tb_systolic_result_packer.sv
// Self-checking bench for systolic_result_packer against a frame-level model.
module tb_systolic_result_packer;

  localparam int N    = 2;
  localparam int DW   = 32;
  localparam int BPW  = DW / 8;
  localparam int FLEN = 2 + N * N * BPW;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*N*DW-1:0] c_flat;
  logic              start;
  logic              tx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              busy;
  logic              done;

  int         checks_total = 0;
  int         checks_pass  = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int         done_cnt;
  int         stall_bad;
  logic       stalled;
  logic [7:0] held;

  systolic_result_packer #(.N(N), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .c_flat   (c_flat),
    .start    (start),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Transfer monitor: records every accepted byte, done pulses and stall stability.
  always @(negedge clk) begin
    if (rst) begin
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (done) done_cnt <= done_cnt + 1;
      if (stalled && (!tx_valid || tx_data !== held)) stall_bad <= stall_bad + 1;
      stalled <= tx_valid && !tx_ready;
      held    <= tx_data;
    end else begin
      stalled <= 1'b0;
    end
  end

  // Reference frame: header, each word's bytes LSB first, XOR of data bytes.
  task automatic build_expected(input logic [N*N*DW-1:0] flat);
    logic [7:0]    cs;
    logic [DW-1:0] w;
    logic [7:0]    b;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    cs = 8'h00;
    for (int k = 0; k < N * N; k++) begin
      w = flat[k*DW +: DW];
      for (int j = 0; j < BPW; j++) begin
        b = 8'((w >> (8 * j)) & 32'hFF);
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    end
    exp_q.push_back(cs);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode: 0 ready high, 1 ready toggles, 2 random ready.
  task automatic send_frame(input int mode, input bit zero_after, input bit restart_mid,
                            output int cycles, output int busy_low, output bit timeout);
    start    = 1'b1;
    tx_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    cycles   = 1;
    busy_low = 0;
    timeout  = 1'b0;
    if (zero_after) c_flat = '0;
    while (done !== 1'b1) begin
      if (busy !== 1'b1) busy_low++;
      if (cycles >= 400) begin
        timeout = 1'b1;
        break;
      end
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      start = restart_mid && (cycles == 6);
      @(posedge clk);
      #1;
      cycles++;
    end
    start    = 1'b0;
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; tx_ready = 1'b1; c_flat = '0;
    done_cnt = 0; stall_bad = 0; stalled = 1'b0;
    idle_cycles(3);
    checks_total++;
    if ({tx_valid, busy, done} !== 3'b000) $display("FAIL reset_ctrl: got %b expected 000", {tx_valid, busy, done});
    else checks_pass++;
    checks_total++;
    if (tx_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", tx_data);
    else checks_pass++;
    rst = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_basic();
    int cyc, bl; bit to;
    c_flat = {32'hFFFFFFFF, 32'h01020304, 32'h00000002, 32'h00000001};
    build_expected(c_flat);
    got.delete(); done_cnt = 0; stall_bad = 0;
    send_frame(0, 1'b0, 1'b0, cyc, bl, to);
    idle_cycles(2);
    checks_total++;
    if (to) $display("FAIL basic_timeout: done not seen within bound");
    else checks_pass++;
    checks_total++;
    if (cyc !== FLEN + 1) $display("FAIL basic_latency: got %0d cycles expected %0d", cyc, FLEN + 1);
    else checks_pass++;
    checks_total++;
    if (bl !== 0) $display("FAIL basic_busy: busy low in %0d cycles expected 0", bl);
    else checks_pass++;
    checks_total++;
    if (got.size() !== FLEN) $display("FAIL basic_len: got %0d bytes expected %0d", got.size(), FLEN);
    else checks_pass++;
    for (int i = 0; i < FLEN && i < got.size(); i++) begin
      checks_total++;
      if (got[i] !== exp_q[i]) $display("FAIL basic_byte%0d: got %h expected %h", i, got[i], exp_q[i]);
      else checks_pass++;
    end
    checks_total++;
    if (got.size() == FLEN && got[FLEN-1] !== 8'h07) $display("FAIL basic_csum: got %h expected 07", got[FLEN-1]);
    else checks_pass++;
    checks_total++;
    if (done_cnt !== 1 || busy !== 1'b0 || tx_valid !== 1'b0)
      $display("FAIL basic_end: done_cnt %0d busy %b valid %b expected 1 0 0", done_cnt, busy, tx_valid);
    else checks_pass++;
  endtask

  task automatic test_stall();
    int cyc, bl; bit to;
    c_flat = {32'hFFFFFFFF, 32'h01020304, 32'h00000002, 32'h00000001};
    build_expected(c_flat);
    got.delete(); done_cnt = 0; stall_bad = 0;
    send_frame(1, 1'b0, 1'b0, cyc, bl, to);
    idle_cycles(2);
    checks_total++;
    if (to || got.size() !== FLEN) $display("FAIL stall_len: got %0d bytes timeout %b expected %0d", got.size(), to, FLEN);
    else checks_pass++;
    for (int i = 0; i < FLEN && i < got.size(); i++) begin
      checks_total++;
      if (got[i] !== exp_q[i]) $display("FAIL stall_byte%0d: got %h expected %h", i, got[i], exp_q[i]);
      else checks_pass++;
    end
    checks_total++;
    if (stall_bad !== 0 || bl !== 0) $display("FAIL stall_hold: unstable %0d busy_low %0d expected 0 0", stall_bad, bl);
    else checks_pass++;
    checks_total++;
    if (done_cnt !== 1) $display("FAIL stall_done: got %0d pulses expected 1", done_cnt);
    else checks_pass++;
  endtask

  task automatic test_capture_hold();
    int cyc, bl; bit to;
    c_flat = {32'hFFFFFFFF, 32'h01020304, 32'h00000002, 32'h00000001};
    build_expected(c_flat);
    got.delete(); done_cnt = 0; stall_bad = 0;
    send_frame(0, 1'b1, 1'b0, cyc, bl, to);
    idle_cycles(2);
    checks_total++;
    if (to || got.size() !== FLEN) $display("FAIL hold_len: got %0d bytes expected %0d", got.size(), FLEN);
    else checks_pass++;
    for (int i = 0; i < FLEN && i < got.size(); i++) begin
      checks_total++;
      if (got[i] !== exp_q[i]) $display("FAIL hold_byte%0d: got %h expected %h", i, got[i], exp_q[i]);
      else checks_pass++;
    end
  endtask

  task automatic test_restart_ignored();
    int cyc, bl; bit to;
    c_flat = {32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF, 32'h0BADF00D};
    build_expected(c_flat);
    c_flat = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    c_flat = {32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF, 32'h0BADF00D};
    got.delete(); done_cnt = 0; stall_bad = 0;
    send_frame(0, 1'b0, 1'b1, cyc, bl, to);
    idle_cycles(4);
    checks_total++;
    if (to || got.size() !== FLEN || done_cnt !== 1)
      $display("FAIL restart_single: bytes %0d pulses %0d expected %0d 1", got.size(), done_cnt, FLEN);
    else checks_pass++;
    for (int i = 0; i < FLEN && i < got.size(); i++) begin
      checks_total++;
      if (got[i] !== exp_q[i]) $display("FAIL restart_byte%0d: got %h expected %h", i, got[i], exp_q[i]);
      else checks_pass++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int n, cyc, bl; bit to;
    c_flat = {32'hCAFEF00D, 32'h12345678, 32'h00FF00FF, 32'hA5A5A5A5};
    build_expected(c_flat);
    got.delete(); done_cnt = 0;
    start = 1'b1; tx_ready = 1'b1;
    idle_cycles(1);
    start = 1'b0;
    n = 0;
    while (got.size() < 5 && n < 100) begin
      idle_cycles(1);
      n++;
    end
    checks_total++;
    if (got.size() < 5) $display("FAIL midrst_progress: got %0d bytes expected 5", got.size());
    else checks_pass++;
    rst = 1'b0;
    #1;
    checks_total++;
    if ({tx_valid, busy, done} !== 3'b000) $display("FAIL midrst_ctrl: got %b expected 000", {tx_valid, busy, done});
    else checks_pass++;
    idle_cycles(2);
    rst = 1'b1;
    idle_cycles(2);
    checks_total++;
    if (done_cnt !== 0 || tx_valid !== 1'b0) $display("FAIL midrst_abort: pulses %0d valid %b expected 0 0", done_cnt, tx_valid);
    else checks_pass++;
    got.delete(); stall_bad = 0;
    send_frame(0, 1'b0, 1'b0, cyc, bl, to);
    idle_cycles(2);
    checks_total++;
    if (to || got.size() !== FLEN) $display("FAIL midrst_len: got %0d bytes expected %0d", got.size(), FLEN);
    else checks_pass++;
    for (int i = 0; i < FLEN && i < got.size(); i++) begin
      checks_total++;
      if (got[i] !== exp_q[i]) $display("FAIL midrst_byte%0d: got %h expected %h", i, got[i], exp_q[i]);
      else checks_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int cyc1, cyc2, bl; bit to1, to2;
    c_flat = '0;
    build_expected(c_flat);
    got.delete(); done_cnt = 0; stall_bad = 0;
    send_frame(0, 1'b0, 1'b0, cyc1, bl, to1);
    send_frame(0, 1'b0, 1'b0, cyc2, bl, to2);
    idle_cycles(2);
    checks_total++;
    if (to1 || to2 || cyc2 !== FLEN + 1) $display("FAIL b2b_latency: got %0d cycles expected %0d", cyc2, FLEN + 1);
    else checks_pass++;
    checks_total++;
    if (got.size() !== 2 * FLEN || done_cnt !== 2)
      $display("FAIL b2b_count: bytes %0d pulses %0d expected %0d 2", got.size(), done_cnt, 2 * FLEN);
    else checks_pass++;
    for (int i = 0; i < 2 * FLEN && i < got.size(); i++) begin
      checks_total++;
      if (got[i] !== exp_q[i % FLEN]) $display("FAIL b2b_byte%0d: got %h expected %h", i, got[i], exp_q[i % FLEN]);
      else checks_pass++;
    end
  endtask

  task automatic test_random();
    int cyc, bl; bit to;
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < N * N; k++) c_flat[k*DW +: DW] = $urandom;
      build_expected(c_flat);
      got.delete(); done_cnt = 0; stall_bad = 0;
      send_frame(2, 1'b0, 1'b0, cyc, bl, to);
      idle_cycles(2);
      checks_total++;
      if (to || got.size() !== FLEN || done_cnt !== 1 || stall_bad !== 0)
        $display("FAIL rand%0d_frame: bytes %0d pulses %0d unstable %0d expected %0d 1 0", f, got.size(), done_cnt, stall_bad, FLEN);
      else checks_pass++;
      for (int i = 0; i < FLEN && i < got.size(); i++) begin
        checks_total++;
        if (got[i] !== exp_q[i]) $display("FAIL rand%0d_byte%0d: got %h expected %h", f, i, got[i], exp_q[i]);
        else checks_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_capture_hold();
    test_restart_ignored();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule

// File: doc/systolic_result_packer.md
Name: systolic_result_packer

Overview:
Downstream stage of the systolic array. It captures the N x N accumulated results (the c_out of every systolic_unit) on a single capture pulse and serialises them as a byte frame for the UART transmitter. The frame is: header byte, result bytes, XOR checksum byte. Byte output uses a valid/ready handshake toward the UART TX block.

Parameters:
N, 2, array dimension; the frame carries N*N result words
DW, 32, result word width in bits; must be a multiple of 8
HDR, 8'hA5, frame header byte

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  asynchronous, active-low reset (asserted when 0)
c_flat  input  N*N*DW  array results, row-major; word k = c_flat[k*DW +: DW], k = row*N + col
start  input  1  capture-and-send request, sampled in IDLE only
tx_ready  input  1  UART TX can accept a byte this cycle
tx_data  output  8  byte presented to UART TX
tx_valid  output  1  tx_data is valid
busy  output  1  high from the cycle after start is accepted until the cycle done pulses
done  output  1  one-cycle pulse after the checksum byte transfers

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; tx_data=0, tx_valid=0, busy=0, done=0; word index, byte index, checksum and capture buffer all cleared. A frame in progress is aborted with no partial completion and no done pulse.
- Transfer: a byte transfers on a clk edge where tx_valid && tx_ready. While tx_valid=1 and tx_ready=0, tx_data is held stable and tx_valid stays high. tx_valid never drops without a transfer, except on reset.
- States:
  - IDLE: if start=1, latch all of c_flat into the internal buffer, clear indices and checksum, and go to HDR. Registered outputs: busy=1 and tx_valid=1 with tx_data=HDR on the next cycle.
  - HDR: on transfer, go to DATA and present byte 0 of word 0.
  - DATA: bytes go out little-endian within a word (bits 7:0 first), words in order k=0..N*N-1. Each transfer XORs the byte into the checksum and advances the byte index. The byte index wraps from DW/8-1 to 0 and increments the word index. After the last byte of word N*N-1, go to CSUM.
  - CSUM: present the XOR of all data bytes; the header is excluded. On transfer, go to IDLE, pulse done=1 for one cycle, and set busy=0 and tx_valid=0.
- Back-to-back: a new frame can start in the cycle after done, because start is sampled in IDLE.
- start while busy: ignored; the buffer is not re-captured.
- The captured buffer is immune to c_flat changes after capture.
- Frame length is 2 + N*N*DW/8 bytes. With tx_ready tied high, there is one byte per cycle and the minimum latency from the start edge to the done pulse is frame length + 1 cycles.
- The checksum register is 8 bits and XOR-only, so it cannot overflow.
- Index widths are $clog2(N*N) and $clog2(DW/8), each with a minimum of 1.

Decomposition:
- Shared package (accelerator-wide): a state enum {IDLE, HDR, DATA, CSUM}, the frame header constant 8'hA5, and a localparam for bytes per word (DW/8).
- One natural sub-module: word_byte_mux. It is combinational and selects byte j of word k from the capture buffer. Everything else (FSM, counters, checksum) stays in the top module.

Test Plan:
- N=2, DW=32, c = {1, 2, 0x01020304, 0xFFFFFFFF}, tx_ready=1, start pulse -> bytes A5, 01 00 00 00, 02 00 00 00, 04 03 02 01, FF FF FF FF, 07; done pulses 19 cycles after the start edge; busy high throughout.
- Same frame with tx_ready toggling 1/0 on alternate cycles -> identical byte sequence, tx_data stable during stalls, no duplicated or dropped bytes.
- Change c_flat to all-zero the cycle after start -> transmitted words still equal the captured values; checksum is 07.
- start re-asserted in DATA -> ignored: a single frame of 18 bytes and a single done pulse.
- rst=0 asserted mid-DATA (after 5 bytes) -> tx_valid, busy and done are 0 immediately. After release, a new start yields a full correct frame beginning with A5.
- All results 0 -> A5, sixteen 00 bytes, checksum 00; then start in the cycle after done -> second identical frame with no idle gap beyond the IDLE cycle.
